// File: rtl/asv_pkg.sv
// Shared definitions for the asv video framing convention: generator states,
// tuser bit positions and a counter-width helper.
package asv_pkg;

    typedef enum logic [1:0] {
        GEN_IDLE   = 2'd0,
        GEN_ACTIVE = 2'd1,
        GEN_HBLANK = 2'd2,
        GEN_VBLANK = 2'd3
    } asv_gen_state_t;

    localparam int ASV_SOF = 0;
    localparam int ASV_SOL = 1;
    localparam int ASV_EOF = 2;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int asv_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/asv_gen_counter.sv
// Pixel/line position counter for the frame generator; exposes next-state values and terminal counts.
// Advances one pixel per accepted beat, wrapping line and frame; no backpressure of its own.
module asv_gen_counter
    import asv_pkg::*;
#(
    parameter int W = 16,
    parameter int H = 8,
    localparam int PW = asv_width(W),
    localparam int LW = asv_width(H)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          adv_i,
    output logic [PW-1:0] pix_d_o,
    output logic [LW-1:0] ln_d_o,
    output logic          px_last_o,
    output logic          ln_last_o
);

    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] ln_q, ln_d;

    assign px_last_o = (pix_q == PW'(W - 1));
    assign ln_last_o = (ln_q == LW'(H - 1));

    always_comb begin
        pix_d = pix_q;
        ln_d  = ln_q;
        if (adv_i) begin
            if (px_last_o) begin
                pix_d = '0;
                ln_d  = ln_last_o ? '0 : ln_q + 1'b1;
            end else begin
                pix_d = pix_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q <= '0;
            ln_q  <= '0;
        end else begin
            pix_q <= pix_d;
            ln_q  <= ln_d;
        end
    end

    assign pix_d_o = pix_d;
    assign ln_d_o  = ln_d;

endmodule

// File: rtl/asv_frame_gen.sv
// AXI4-Stream counting-pattern frame source; every output is registered, so decode runs on next-state values.
// A beat holds until tvalid && tready; blanking appears as tvalid-low cycles.
module asv_frame_gen
    import asv_pkg::*;
#(
    parameter int W  = 16,
    parameter int H  = 8,
    parameter int HB = 2,
    parameter int VB = 4,
    parameter int N  = 2,
    parameter int U  = 3
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           enable,
    output logic           tvalid,
    input  logic           tready,
    output logic [8*N-1:0] tdata,
    output logic           tlast,
    output logic [U-1:0]   tuser,
    output logic           busy,
    output logic           frame_done,
    output logic [15:0]    frame_cnt
);

    localparam int PW = asv_width(W);
    localparam int LW = asv_width(H);
    localparam int BW = asv_width((HB > VB) ? HB : VB);
    localparam int DW = 8 * N;
    localparam logic [BW-1:0] HB_LAST = BW'((HB > 0) ? HB - 1 : 0);
    localparam logic [BW-1:0] VB_LAST = BW'((VB > 0) ? VB - 1 : 0);

    asv_gen_state_t state_q, state_d;
    logic [BW-1:0]  blank_q, blank_d;
    logic [15:0]    fcnt_q, fcnt_d;
    logic           tvalid_q, tlast_q, tlast_d, busy_q, done_q, done_d;
    logic [DW-1:0]  tdata_q, tdata_d;
    logic [U-1:0]   tuser_q, tuser_d;
    logic [PW-1:0]  pix_d;
    logic [LW-1:0]  ln_d;
    logic           px_last, ln_last, fire;
    logic [DW+15:0] beat_wide;

    assign fire = tvalid_q & tready;

    asv_gen_counter #(.W(W), .H(H)) u_cnt (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .adv_i     (fire),
        .pix_d_o   (pix_d),
        .ln_d_o    (ln_d),
        .px_last_o (px_last),
        .ln_last_o (ln_last)
    );

    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        done_d  = 1'b0;
        case (state_q)
            GEN_IDLE: if (enable) state_d = GEN_ACTIVE;
            GEN_ACTIVE: begin
                if (fire && px_last) begin
                    if (!ln_last) begin
                        state_d = (HB > 0) ? GEN_HBLANK : GEN_ACTIVE;
                    end else begin
                        done_d  = 1'b1;
                        if (VB > 0) state_d = GEN_VBLANK;
                        else        state_d = enable ? GEN_ACTIVE : GEN_IDLE;
                    end
                end
            end
            GEN_HBLANK: begin
                if (blank_q == HB_LAST) begin
                    blank_d = '0;
                    state_d = GEN_ACTIVE;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            GEN_VBLANK: begin
                // enable is only consulted on the last blank cycle of the frame gap
                if (blank_q == VB_LAST) begin
                    blank_d = '0;
                    state_d = enable ? GEN_ACTIVE : GEN_IDLE;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            default: state_d = GEN_IDLE;
        endcase
    end

    assign fcnt_d = done_d ? fcnt_q + 16'd1 : fcnt_q;

    always_comb begin
        beat_wide = {DW'(fcnt_d), 8'(ln_d), 8'(pix_d)};
        tdata_d   = '0;
        tlast_d   = 1'b0;
        tuser_d   = '0;
        if (state_d == GEN_ACTIVE) begin
            tdata_d          = beat_wide[DW-1:0];
            tlast_d          = (pix_d == PW'(W - 1));
            tuser_d[ASV_SOF] = (pix_d == '0) && (ln_d == '0);
            tuser_d[ASV_SOL] = (pix_d == '0);
            tuser_d[ASV_EOF] = (pix_d == PW'(W - 1)) && (ln_d == LW'(H - 1));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= GEN_IDLE;
            blank_q  <= '0;
            fcnt_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            blank_q  <= blank_d;
            fcnt_q   <= fcnt_d;
            tvalid_q <= (state_d == GEN_ACTIVE);
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            busy_q   <= (state_d != GEN_IDLE);
            done_q   <= done_d;
        end
    end

    assign tvalid     = tvalid_q;
    assign tdata      = tdata_q;
    assign tlast      = tlast_q;
    assign tuser      = tuser_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule
